// File: rtl/z80_pin_pkg.sv
// rtl/z80_pin_pkg.sv - shared modes and channel indices for the bus pin multiplexer
package z80_pin_pkg;

    localparam logic [1:0] MODE_LIVE      = 2'b00;
    localparam logic [1:0] MODE_SNAP      = 2'b01;
    localparam logic [1:0] MODE_SCAN      = 2'b10;
    localparam logic [1:0] MODE_SCAN_HOLD = 2'b11;

    // Default channel assignment on the Z80 top level
    localparam int CH_ALO  = 0;
    localparam int CH_AHI  = 1;
    localparam int CH_CTRL = 2;
    localparam int CH_DOUT = 3;

    function automatic logic is_scan_mode(input logic [1:0] m);
        return (m == MODE_SCAN) || (m == MODE_SCAN_HOLD);
    endfunction

endpackage

// File: rtl/bus_snapshot_bank.sv
// rtl/bus_snapshot_bank.sv - shadow copy of all channels with read mux and load counter
module bus_snapshot_bank #(
    parameter int PIN_W  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cen_i,
    input  logic                     load_i,
    input  logic [NUM_CH*PIN_W-1:0]  data_i,
    input  logic [SEL_W-1:0]         rd_idx_i,
    output logic [PIN_W-1:0]         rd_data_o,
    output logic [3:0]               seq_o
);

    logic [NUM_CH*PIN_W-1:0] shadow_q;
    logic [3:0]              seq_q;

    // Whole-bank load so every channel comes from the same clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            seq_q    <= '0;
        end else if (cen_i && load_i) begin
            shadow_q <= data_i;
            seq_q    <= seq_q + 4'd1;
        end
    end

    // Read mux; indices past the last channel read as zero
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(rd_idx_i) == k) begin
                rd_data_o = shadow_q[k*PIN_W +: PIN_W];
            end
        end
    end

    assign seq_o = seq_q;

endmodule

// File: rtl/bus_pin_mux.sv
// rtl/bus_pin_mux.sv - time-multiplexes byte channels onto output pins with snapshot and scan modes
module bus_pin_mux
    import z80_pin_pkg::*;
#(
    parameter int PIN_W  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cen,
    input  logic [NUM_CH*PIN_W-1:0]  ch_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic [1:0]               mode,
    input  logic                     cap_n,
    output logic [PIN_W-1:0]         pins,
    output logic [SEL_W-1:0]         ch_out,
    output logic                     frame_start,
    output logic [3:0]               snap_seq
);

    logic             cap_prev_q, cap_prev_d;
    logic             pending_q, pending_d;
    logic             in_scan_q, in_scan_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [PIN_W-1:0] pins_q, pins_d;
    logic [SEL_W-1:0] ch_out_q, ch_out_d;
    logic             frame_start_q, frame_start_d;

    logic             cap_evt;
    logic             scan_mode;
    logic             last_ch;
    logic             scan_load;
    logic             bank_load;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] rd_idx;
    logic [PIN_W-1:0] live_byte;
    logic [PIN_W-1:0] bank_byte;

    // Capture edge, next scan channel and whether the shadow reloads this edge
    always_comb begin
        cap_evt   = ~cap_n & cap_prev_q;
        scan_mode = is_scan_mode(mode);
        last_ch   = (cnt_q == SEL_W'(NUM_CH - 1));
        // A fresh entry into scanning restarts the frame at channel 0
        scan_idx  = (!in_scan_q || last_ch) ? '0 : cnt_q + SEL_W'(1);
        // Frame boundary loads when entering, in plain SCAN, or when a capture is pending
        // (including one arriving on this very edge)
        scan_load = (scan_idx == '0) &&
                    (!in_scan_q || (mode == MODE_SCAN) || pending_q || cap_evt);
        bank_load = scan_mode ? scan_load : ((mode == MODE_SNAP) && cap_evt);
        rd_idx    = scan_mode ? scan_idx : sel;
        live_byte = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(sel) == k) begin
                live_byte = ch_data[k*PIN_W +: PIN_W];
            end
        end
    end

    bus_snapshot_bank #(
        .PIN_W  (PIN_W),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen_i     (cen),
        .load_i    (bank_load),
        .data_i    (ch_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bank_byte),
        .seq_o     (snap_seq)
    );

    // Next pin tuple and mode bookkeeping
    always_comb begin
        cap_prev_d    = cap_n;
        pending_d     = 1'b0;
        in_scan_d     = 1'b0;
        cnt_d         = '0;
        pins_d        = '0;
        ch_out_d      = sel;
        frame_start_d = 1'b0;
        case (mode)
            MODE_LIVE: begin
                pins_d = live_byte;
            end
            MODE_SNAP: begin
                // Reads the shadow as it was before any load on this edge
                pins_d = bank_byte;
            end
            default: begin
                // On a load edge channel 0 is taken straight from the inputs being
                // captured, so the whole frame matches the new shadow
                pins_d        = scan_load ? ch_data[CH_ALO*PIN_W +: PIN_W] : bank_byte;
                ch_out_d      = scan_idx;
                frame_start_d = (scan_idx == '0);
                cnt_d         = scan_idx;
                in_scan_d     = 1'b1;
                pending_d     = scan_load ? 1'b0 : (pending_q | cap_evt);
            end
        endcase
    end

    // State and registered outputs; everything holds while cen is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_prev_q    <= 1'b1;
            pending_q     <= 1'b0;
            in_scan_q     <= 1'b0;
            cnt_q         <= '0;
            pins_q        <= '0;
            ch_out_q      <= '0;
            frame_start_q <= 1'b0;
        end else if (cen) begin
            cap_prev_q    <= cap_prev_d;
            pending_q     <= pending_d;
            in_scan_q     <= in_scan_d;
            cnt_q         <= cnt_d;
            pins_q        <= pins_d;
            ch_out_q      <= ch_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pins        = pins_q;
    assign ch_out      = ch_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bus_pin_mux.sv
// tb/tb_bus_pin_mux.sv - self-checking bench for bus_pin_mux with a behavioural model
module tb_bus_pin_mux;
    import z80_pin_pkg::*;

    localparam int PIN_W  = 8;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic [31:0] ch_data;
    logic [2:0]  sel;
    logic [1:0]  mode;
    logic        cap_n;
    logic [7:0]  pins;
    logic [2:0]  ch_out;
    logic        frame_start;
    logic [3:0]  snap_seq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_pin_mux #(
        .PIN_W  (PIN_W),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .ch_data     (ch_data),
        .sel         (sel),
        .mode        (mode),
        .cap_n       (cap_n),
        .pins        (pins),
        .ch_out      (ch_out),
        .frame_start (frame_start),
        .snap_seq    (snap_seq)
    );

    // Behavioural model state
    logic [7:0] m_sh [NUM_CH];
    int         m_seq;
    bit         m_pend;
    bit         m_prev;
    bit         m_scan;
    int         m_idx;
    logic [7:0] e_pins;
    int         e_ch;
    bit         e_fs;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_sh[k] = 8'h00;
        m_seq = 0; m_pend = 0; m_prev = 1; m_scan = 0; m_idx = 0;
        e_pins = 8'h00; e_ch = 0; e_fs = 0;
    endtask

    task automatic model_load();
        for (int k = 0; k < NUM_CH; k++) m_sh[k] = ch_data[k*8 +: 8];
        m_seq = (m_seq + 1) % 16;
    endtask

    task automatic model_edge();
        bit evt;
        bit fresh;
        if (cen !== 1'b1) return;
        evt    = (cap_n == 1'b0) && m_prev;
        m_prev = cap_n;
        if (mode == MODE_SCAN || mode == MODE_SCAN_HOLD) begin
            m_idx = m_scan ? (m_idx + 1) % NUM_CH : 0;
            fresh = (m_idx == 0) && (!m_scan || mode == MODE_SCAN || m_pend || evt);
            if (fresh) begin
                model_load();
                m_pend = 0;
            end else if (evt) begin
                m_pend = 1;
            end
            e_pins = m_sh[m_idx];
            e_ch   = m_idx;
            e_fs   = (m_idx == 0);
            m_scan = 1;
        end else begin
            e_ch   = int'(sel);
            e_fs   = 0;
            m_pend = 0;
            m_scan = 0;
            if (int'(sel) >= NUM_CH)     e_pins = 8'h00;
            else if (mode == MODE_LIVE)  e_pins = ch_data[int'(sel)*8 +: 8];
            else                         e_pins = m_sh[int'(sel)];
            if (mode == MODE_SNAP && evt) model_load();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; cen = 1; cap_n = 1; mode = MODE_LIVE; sel = 0; ch_data = 32'h0;
        model_reset();
        #22;
        n_tests++; if (pins !== 8'h00)     begin n_fail++; $display("FAIL reset_pins got %h want 00", pins); end
        n_tests++; if (ch_out !== 3'd0)    begin n_fail++; $display("FAIL reset_ch_out got %0d want 0", ch_out); end
        n_tests++; if (frame_start !== 0)  begin n_fail++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        n_tests++; if (snap_seq !== 4'd0)  begin n_fail++; $display("FAIL reset_snap_seq got %0d want 0", snap_seq); end
        rst_n = 1;
    endtask

    task automatic test_live();
        mode = MODE_LIVE; ch_data = 32'h44332211; sel = 3'd2;
        step();
        n_tests++; if (pins !== 8'h33)   begin n_fail++; $display("FAIL live_pins got %h want 33", pins); end
        n_tests++; if (ch_out !== 3'd2)  begin n_fail++; $display("FAIL live_ch_out got %0d want 2", ch_out); end
        sel = 3'd5;
        step();
        n_tests++; if (pins !== 8'h00)   begin n_fail++; $display("FAIL live_oor_pins got %h want 00", pins); end
        n_tests++; if (ch_out !== 3'd5)  begin n_fail++; $display("FAIL live_oor_ch_out got %0d want 5", ch_out); end
    endtask

    task automatic test_snap();
        mode = MODE_SNAP; sel = 3'(CH_ALO); ch_data = 32'h4433BEEF; cap_n = 1;
        step();
        cap_n = 0;
        step();
        ch_data = 32'h44331234;
        step();
        n_tests++; if (pins !== 8'hEF)   begin n_fail++; $display("FAIL snap_lo got %h want ef", pins); end
        sel = 3'(CH_AHI);
        step();
        n_tests++; if (pins !== 8'hBE)   begin n_fail++; $display("FAIL snap_hi got %h want be", pins); end
        n_tests++; if (snap_seq !== 4'd1) begin n_fail++; $display("FAIL snap_seq got %0d want 1", snap_seq); end
        cap_n = 1;
        step();
        n_tests++; if (pins !== 8'hBE)   begin n_fail++; $display("FAIL snap_hold got %h want be", pins); end
    endtask

    task automatic test_scan();
        logic [31:0] old_frame;
        old_frame = 32'hD4C3B2A1;
        mode = MODE_SCAN; ch_data = old_frame;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) ch_data = 32'h00000000;
            n_tests++; if (int'(ch_out) != i % NUM_CH) begin n_fail++; $display("FAIL scan_ch_out[%0d] got %0d want %0d", i, ch_out, i % NUM_CH); end
            n_tests++; if (frame_start !== (i % NUM_CH == 0)) begin n_fail++; $display("FAIL scan_frame_start[%0d] got %b", i, frame_start); end
            if (i < 4) begin
                n_tests++; if (pins !== old_frame[i*8 +: 8]) begin n_fail++; $display("FAIL scan_pins[%0d] got %h want %h", i, pins, old_frame[i*8 +: 8]); end
            end else begin
                n_tests++; if (pins !== 8'h00) begin n_fail++; $display("FAIL scan_newframe got %h want 00", pins); end
            end
        end
        n_tests++; if (int'(snap_seq) != m_seq) begin n_fail++; $display("FAIL scan_seq got %0d want %0d", snap_seq, m_seq); end
    endtask

    task automatic test_scan_hold();
        int  seq0;
        bit  found;
        mode = MODE_SCAN_HOLD; cap_n = 1;
        seq0 = m_seq;
        for (int i = 0; i < 12; i++) begin
            ch_data = $urandom;
            step();
            n_tests++; if (pins !== e_pins || int'(snap_seq) != seq0) begin n_fail++; $display("FAIL hold_repeat[%0d] pins %h want %h seq %0d want %0d", i, pins, e_pins, snap_seq, seq0); end
        end
        cap_n = 0; step(); cap_n = 1;
        found = 0;
        for (int i = 0; i < 2 * NUM_CH && !found; i++) begin
            ch_data = $urandom;
            step();
            if (ch_out == 3'd0) found = 1;
        end
        n_tests++; if (!found || int'(snap_seq) != (seq0 + 1) % 16 || pins !== ch_data[7:0]) begin n_fail++; $display("FAIL hold_event seq %0d want %0d pins %h want %h", snap_seq, (seq0 + 1) % 16, pins, ch_data[7:0]); end
        found = 0;
        for (int i = 0; i < 2 * NUM_CH && !found; i++) begin
            step();
            if (int'(ch_out) == NUM_CH - 1) found = 1;
        end
        cap_n = 0; ch_data = $urandom;
        step();
        n_tests++; if (!found || int'(snap_seq) != (seq0 + 2) % 16 || pins !== ch_data[7:0]) begin n_fail++; $display("FAIL hold_wrap_event seq %0d want %0d pins %h", snap_seq, (seq0 + 2) % 16, pins); end
        cap_n = 1;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data = $urandom;
            step();
        end
        n_tests++; if (ch_out !== 3'd0 || int'(snap_seq) != (seq0 + 2) % 16) begin n_fail++; $display("FAIL hold_pending_clear ch %0d seq %0d want %0d", ch_out, snap_seq, (seq0 + 2) % 16); end
    endtask

    task automatic test_cen_freeze();
        logic [7:0] s_pins;
        logic [2:0] s_ch;
        logic [3:0] s_seq;
        mode = MODE_SCAN; cap_n = 1;
        step(); step();
        s_pins = e_pins; s_ch = 3'(e_ch); s_seq = 4'(m_seq);
        cen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cap_n = 0;
            ch_data = $urandom;
            step();
            n_tests++; if (pins !== s_pins || ch_out !== s_ch || snap_seq !== s_seq) begin n_fail++; $display("FAIL cen_freeze[%0d] pins %h/%h ch %0d/%0d seq %0d/%0d", i, pins, s_pins, ch_out, s_ch, snap_seq, s_seq); end
        end
        cen = 1;
        step();
        n_tests++; if (int'(ch_out) != (int'(s_ch) + 1) % NUM_CH || pins !== e_pins) begin n_fail++; $display("FAIL cen_resume ch %0d want %0d pins %h want %h", ch_out, (int'(s_ch) + 1) % NUM_CH, pins, e_pins); end
        cap_n = 1;
    endtask

    task automatic test_reset_mid();
        bit found;
        mode = MODE_SCAN;
        found = 0;
        for (int i = 0; i < 2 * NUM_CH && !found; i++) begin
            step();
            if (ch_out == 3'd2) found = 1;
        end
        #2 rst_n = 0;
        #1;
        n_tests++; if (!found || pins !== 8'h00 || ch_out !== 3'd0 || frame_start !== 1'b0 || snap_seq !== 4'd0) begin n_fail++; $display("FAIL reset_mid pins %h ch %0d fs %b seq %0d want all 0", pins, ch_out, frame_start, snap_seq); end
        model_reset();
        ch_data = 32'h5A6B7C8D;
        #1 rst_n = 1;
        step();
        n_tests++; if (ch_out !== 3'd0 || frame_start !== 1'b1 || pins !== 8'h8D || snap_seq !== 4'd1) begin n_fail++; $display("FAIL reset_restart ch %0d fs %b pins %h seq %0d want 0 1 8d 1", ch_out, frame_start, pins, snap_seq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cen     = ($urandom_range(0, 7) != 0);
            cap_n   = ($urandom_range(0, 3) != 0);
            sel     = 3'($urandom_range(0, 5));
            ch_data = $urandom;
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            step();
            n_tests++;
            if (pins !== e_pins || int'(ch_out) != e_ch || frame_start !== e_fs || int'(snap_seq) != m_seq) begin
                n_fail++;
                $display("FAIL random[%0d] mode %0d pins %h/%h ch %0d/%0d fs %b/%b seq %0d/%0d", i, mode, pins, e_pins, ch_out, e_ch, frame_start, e_fs, snap_seq, m_seq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_live();
        test_snap();
        test_scan();
        test_scan_hold();
        test_cen_freeze();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
